// File: rtl/tdc_tap_sampler_pkg.sv
// Shared definitions for the TDC tap sampler: default line length and the
// measurement FSM state encoding.
package tdc_tap_sampler_pkg;

  // Default number of delay-line taps sampled.
  localparam int TDC_TAPS = 64;

  // Measurement FSM states. ST_SPARE is never entered; it recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_VALID = 2'd2,
    ST_SPARE = 2'd3
  } tdc_state_e;

endpackage

// File: rtl/tdc_popcount.sv
// Combinational population count of the resynchronised tap vector.
// Counting every '1' tap (rather than locating the 0/1 boundary) tolerates
// bubbles in the thermometer code. The caller registers the output.
module tdc_popcount #(
  parameter int TAPS  = 64,
  parameter int CNT_W = 7
) (
  input  logic [TAPS-1:0]  taps,
  output logic [CNT_W-1:0] count
);

  // Sum all tap bits; CNT_W is wide enough that the sum cannot wrap.
  always_comb begin
    count = '0;
    for (int i = 0; i < TAPS; i++) begin
      count = count + CNT_W'(taps[i]);
    end
  end

endmodule

// File: rtl/tdc_tap_sampler.sv
// TDC tap sampler: double-flop resynchronisation of the delay-line taps,
// registered popcount, and a one-shot measurement FSM that returns one
// result per ARM on a valid/ready port.
//
// Result handshake: result_valid rises with the captured result and stays
// high, with result/result_sat/result_to stable, until a cycle where
// result_valid & result_ready are both high; that cycle is the transfer and
// result_valid falls on the following cycle. result/flags then keep their
// last values.
module tdc_tap_sampler
  import tdc_tap_sampler_pkg::*;
#(
  parameter int TAPS        = TDC_TAPS,
  parameter int CNT_W       = 7,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAPS-1:0]  taps_in,
  input  logic             arm,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_sat,
  output logic             result_to,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [1:0]       dbg_state
);

  (* keep *) logic [TAPS-1:0] s1;
  (* keep *) logic [TAPS-1:0] s2;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] pc_next;
  logic             hit;
  logic             sat;
  logic [TO_W-1:0]  to_cnt;
  logic             to_last;
  tdc_state_e       state;
  tdc_state_e       state_next;

  tdc_popcount #(
    .TAPS  (TAPS),
    .CNT_W (CNT_W)
  ) u_popcount (
    .taps  (s2),
    .count (pc_next)
  );

  assign hit     = (pc != '0);
  assign sat     = (pc == CNT_W'(TAPS));
  assign to_last = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Resync and popcount pipeline; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      pc <= '0;
    end else begin
      s1 <= taps_in;
      s2 <= s1;
      pc <= pc_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a hit wins over timeout; ARM is ignored while VALID.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (arm) state_next = ST_ARMED;
      ST_ARMED: begin
        if (hit) begin
          state_next = ST_VALID;
        end else if (!arm && to_last) begin
          state_next = ST_VALID;
        end
      end
      ST_VALID: if (result_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    busy         = (state != ST_IDLE);
    result_valid = (state == ST_VALID);
    dbg_state    = state;
  end

  // Timeout counter and result capture. The counter stops at the compare
  // value because the FSM leaves ARMED there, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      result     <= '0;
      result_sat <= 1'b0;
      result_to  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) to_cnt <= '0;
        end
        ST_ARMED: begin
          if (hit) begin
            result     <= pc;
            result_sat <= sat;
            result_to  <= 1'b0;
          end else if (arm) begin
            to_cnt <= '0;
          end else if (to_last) begin
            result     <= '0;
            result_sat <= 1'b0;
            result_to  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_tap_sampler.sv
// Bench for tdc_tap_sampler: directed scenarios plus randomized measurements,
// compared every cycle against a timeline model built on per-edge tap counts.
module tb_tdc_tap_sampler;

  localparam int TAPS        = 64;
  localparam int CNT_W       = 7;
  localparam int TIMEOUT_CYC = 10;
  localparam int TO_W        = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [TAPS-1:0]  taps_in;
  logic             arm;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_sat;
  logic             result_to;
  logic             result_valid;
  logic             result_ready;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  tdc_tap_sampler #(
    .TAPS        (TAPS),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .taps_in      (taps_in),
    .arm          (arm),
    .busy         (busy),
    .result       (result),
    .result_sat   (result_sat),
    .result_to    (result_to),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec  = 0;
  int n_fail = 0;

  // Number of '1' taps sampled at each rising edge (0 while in reset).
  int hist[$];
  // Model of the visible measurement: armed/valid flags, last ARM edge, result.
  bit m_armed;
  bit m_valid;
  int m_last;
  int m_res;
  bit m_sat;
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_armed = 0;
    m_valid = 0;
    m_last  = 0;
    m_res   = 0;
    m_sat   = 0;
    m_to    = 0;
  endtask

  // The count the FSM sees at edge e is the one sampled three edges earlier.
  task automatic model_step(input int e);
    int c3;
    c3 = (e >= 3) ? hist[e-3] : 0;
    if (m_valid) begin
      if (result_ready) m_valid = 0;
    end else if (m_armed) begin
      if (c3 != 0) begin
        m_armed = 0; m_valid = 1; m_res = c3; m_sat = (c3 == TAPS); m_to = 0;
      end else if (arm) begin
        m_last = e;
      end else if (e - m_last == TIMEOUT_CYC) begin
        m_armed = 0; m_valid = 1; m_res = 0; m_sat = 0; m_to = 1;
      end
    end else if (arm) begin
      m_armed = 1;
      m_last  = e;
    end
  endtask

  task automatic check_outputs();
    chk("busy",         busy,         (m_armed || m_valid));
    chk("result_valid", result_valid, m_valid);
    chk("result",       result,       m_res);
    chk("result_sat",   result_sat,   m_sat);
    chk("result_to",    result_to,    m_to);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: record the sample, advance the model, compare on the falling edge.
  task automatic tick();
    int e;
    @(posedge clk);
    hist.push_back(rst_n ? $countones(taps_in) : 0);
    e = hist.size() - 1;
    if (rst_n) model_step(e);
    @(negedge clk);
    check_outputs();
  endtask

  // Assert reset between edges; pipeline samples still in flight are lost.
  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      if (hist.size() > k) hist[hist.size()-1-k] = 0;
    end
    check_outputs();
  endtask

  function automatic logic [TAPS-1:0] thermo(input int n);
    logic [TAPS-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Idle line, ARM, edge after 'delay' cycles (never if <0), optional re-ARM,
  // then hold READY low for 'bp' cycles with noisy taps and stray ARMs.
  task automatic measure(input logic [TAPS-1:0] pat, input int delay,
                         input int rearm_at, input int bp);
    taps_in = '0; arm = 1'b0; result_ready = 1'b0;
    repeat (4) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 40 && !m_valid; k++) begin
      if (k == delay) taps_in = pat;
      arm = (k == rearm_at);
      tick();
    end
    arm = 1'b0;
    chk("meas_done", result_valid, 1'b1);
    for (int k = 0; k < bp; k++) begin
      taps_in = {$urandom, $urandom};
      arm = ($urandom_range(0, 3) == 0);
      tick();
    end
    arm = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    tick();
    chk("meas_idle", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [TAPS-1:0] p;
    model_clear();

    // Reset with the line saturated and ARM held.
    rst_n = 1'b0; taps_in = '1; arm = 1'b1; result_ready = 1'b0;
    #1;
    check_outputs();
    repeat (3) tick();
    arm = 1'b0; taps_in = '0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_reset_busy", busy, 1'b0);

    // Nominal: 16 taps; valid visible after the 4th edge counting the sampling edge.
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    taps_in = 64'h0000_0000_0000_FFFF;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (result_valid) begin n = k; break; end
    end
    chk("nominal_latency", n, 4);
    chk("nominal_result", result, 16);
    chk("nominal_sat", result_sat, 1'b0);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("nominal_drop_valid", result_valid, 1'b0);
    chk("nominal_drop_busy", busy, 1'b0);

    // Bubble and saturation.
    measure(64'h0000_0000_0000_F7FF, 2, -1, 0);
    measure('1, 3, -1, 0);

    // Timeout: ten cycles after the ARM-accept edge.
    taps_in = '0; repeat (4) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (result_valid) begin n = k; break; end
    end
    chk("timeout_latency", n, TIMEOUT_CYC);
    chk("timeout_flag", result_to, 1'b1);
    chk("timeout_result", result, 0);
    result_ready = 1'b1; tick(); result_ready = 1'b0; tick();

    // Timeout with a re-ARM six cycles after the accept edge.
    arm = 1'b1; tick(); arm = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      arm = (k == 6);
      tick();
      arm = 1'b0;
      if (result_valid) begin n = k; break; end
    end
    chk("rearm_timeout_latency", n, 6 + TIMEOUT_CYC);
    result_ready = 1'b1; tick(); result_ready = 1'b0; tick();

    // Backpressure with stray ARMs; result must hold, no new measurement afterwards.
    measure(thermo(23), 1, -1, 20);
    taps_in = '1;
    repeat (5) tick();
    chk("no_rearm_after_accept", busy, 1'b0);

    // Reset in ARMED before the edge arrives.
    taps_in = '0; repeat (4) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (2) tick();
    assert_reset();
    chk("reset_mid_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    taps_in = thermo(40);
    repeat (12) tick();
    chk("reset_mid_no_valid", result_valid, 1'b0);
    taps_in = '0;

    // Randomized measurements: thermometer with optional bubble, saturation,
    // or no edge (timeout), random arrival, re-ARM and backpressure.
    for (int t = 0; t < 30; t++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, TAPS);
      p    = thermo(len);
      if (kind == 1 && len > 2) p[$urandom_range(0, len - 2)] = 1'b0;
      if (kind == 2) p = '1;
      if (kind == 3) p = '0;
      measure(p, $urandom_range(0, 14),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1,
              $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
